// File: rtl/sparse_tok_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sparse_tok_pkg
// Description : Shared sparse-token constants, token classifiers and the
//               stream-arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package sparse_tok_pkg;

    localparam int TOKEN_W = 17;

    localparam logic [TOKEN_W-1:0] DONE_TOKEN      = 17'h10100;
    localparam logic [TOKEN_W-1:0] STOP_TOKEN_BASE = 17'h10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
        return tok == DONE_TOKEN;
    endfunction

    // Stop tokens carry the control flag with a zero opcode byte; the low byte is the level.
    function automatic logic is_stop(input logic [TOKEN_W-1:0] tok);
        return tok[TOKEN_W-1] && (tok[15:8] == 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/repsig_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : repsig_stream_arbiter_if
// Description : Ready/valid sparse token stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface repsig_stream_arbiter_if
    import sparse_tok_pkg::*;
#(
    parameter int DATA_WIDTH = TOKEN_W
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/arb_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_order_fifo
// Description : 1-bit-wide synchronous FIFO recording stream grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_data,
    input  logic i_pop,
    output logic o_head,
    output logic o_empty,
    output logic o_full
);

    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_INC  = c_AW'(1);

    logic [DEPTH-1:0] r_mem;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_INC;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_INC;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // The arbiter only grants while not full, so this must never fire.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule
`default_nettype wire

// File: rtl/repsig_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : repsig_stream_arbiter
// Description : Shares one repeat-signal generator between two requesters,
//               granting and steering at whole-stream (done token) granularity.
// Revision    : 1.0 - initial release
// ============================================================================
module repsig_stream_arbiter #(
    parameter int                    DATA_WIDTH  = sparse_tok_pkg::TOKEN_W,
    parameter logic [DATA_WIDTH-1:0] DONE_TOKEN  = sparse_tok_pkg::DONE_TOKEN,
    parameter int                    ORDER_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic                    tile_en,
    repsig_stream_arbiter_if.slave  req0,
    repsig_stream_arbiter_if.slave  req1,
    repsig_stream_arbiter_if.master shd_in,
    repsig_stream_arbiter_if.slave  shd_out,
    repsig_stream_arbiter_if.master resp0,
    repsig_stream_arbiter_if.master resp1,
    output logic                    busy
);

    localparam logic [1:0] c_IDLE  = 2'(sparse_tok_pkg::IDLE);
    localparam logic [1:0] c_LOCK0 = 2'(sparse_tok_pkg::LOCK0);
    localparam logic [1:0] c_LOCK1 = 2'(sparse_tok_pkg::LOCK1);

    logic [1:0] r_state;
    logic       r_rr;

    logic w_clr;
    logic w_active;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_fifo_head;
    logic w_grant_any;
    logic w_grant_sel;
    logic w_push;
    logic w_pop;
    logic w_in_done;

    // A disabled tile is held in its reset state rather than merely frozen.
    assign w_clr    = rst || flush || !tile_en;
    assign w_active = clk_en && tile_en;

    assign w_grant_any = (r_state == c_IDLE) && !w_fifo_full && (req0.valid || req1.valid);
    assign w_grant_sel = r_rr ? req1.valid : !req0.valid;
    assign w_push      = w_active && w_grant_any;

    always_comb begin
        shd_in.data  = '0;
        shd_in.valid = 1'b0;
        req0.ready   = 1'b0;
        req1.ready   = 1'b0;
        if (w_active) begin
            case (r_state)
                c_LOCK0: begin
                    shd_in.data  = req0.data;
                    shd_in.valid = req0.valid;
                    req0.ready   = shd_in.ready;
                end
                c_LOCK1: begin
                    shd_in.data  = req1.data;
                    shd_in.valid = req1.valid;
                    req1.ready   = shd_in.ready;
                end
                default: ;
            endcase
        end
    end

    assign w_in_done = shd_in.valid && shd_in.ready && (shd_in.data == DONE_TOKEN);

    // Responses follow the order FIFO head; with nothing queued the generator simply stalls.
    always_comb begin
        shd_out.ready = 1'b0;
        resp0.data    = '0;
        resp0.valid   = 1'b0;
        resp1.data    = '0;
        resp1.valid   = 1'b0;
        if (w_active && !w_fifo_empty) begin
            if (w_fifo_head) begin
                resp1.data    = shd_out.data;
                resp1.valid   = shd_out.valid;
                shd_out.ready = resp1.ready;
            end else begin
                resp0.data    = shd_out.data;
                resp0.valid   = shd_out.valid;
                shd_out.ready = resp0.ready;
            end
        end
    end

    assign w_pop = shd_out.valid && shd_out.ready && (shd_out.data == DONE_TOKEN);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= c_IDLE;
            r_rr    <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_any) begin
                        r_state <= w_grant_sel ? c_LOCK1 : c_LOCK0;
                    end
                end
                c_LOCK0: begin
                    if (w_in_done) begin
                        r_state <= c_IDLE;
                        r_rr    <= 1'b1;
                    end
                end
                c_LOCK1: begin
                    if (w_in_done) begin
                        r_state <= c_IDLE;
                        r_rr    <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    arb_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (w_clr),
        .i_push  (w_push),
        .i_data  (w_grant_sel),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign busy = (r_state != c_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_repsig_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_repsig_stream_arbiter
// Description : Directed self-checking bench for repsig_stream_arbiter
//               (order FIFO depth 2 so the full condition is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_repsig_stream_arbiter;

    localparam logic [16:0] c_DONE = 17'h10100;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic flush;
    logic tile_en;
    logic busy;

    int checks = 0;
    int errors = 0;

    repsig_stream_arbiter_if req0_if ();
    repsig_stream_arbiter_if req1_if ();
    repsig_stream_arbiter_if shd_in_if ();
    repsig_stream_arbiter_if shd_out_if ();
    repsig_stream_arbiter_if resp0_if ();
    repsig_stream_arbiter_if resp1_if ();

    repsig_stream_arbiter #(
        .DATA_WIDTH  (17),
        .DONE_TOKEN  (c_DONE),
        .ORDER_DEPTH (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .flush   (flush),
        .tile_en (tile_en),
        .req0    (req0_if),
        .req1    (req1_if),
        .shd_in  (shd_in_if),
        .shd_out (shd_out_if),
        .resp0   (resp0_if),
        .resp1   (resp1_if),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_if.valid    = 1'b0;
        req0_if.data     = '0;
        req1_if.valid    = 1'b0;
        req1_if.data     = '0;
        shd_in_if.ready  = 1'b0;
        shd_out_if.valid = 1'b0;
        shd_out_if.data  = '0;
        resp0_if.ready   = 1'b0;
        resp1_if.ready   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        req0_if.valid = 1'b1; req0_if.data = 17'h5;
        shd_in_if.ready = 1'b1;
        shd_out_if.valid = 1'b1; shd_out_if.data = c_DONE;
        resp0_if.ready = 1'b1;
        #1;
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.valid, shd_out_if.ready, resp0_if.valid, resp1_if.valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshake got %b exp 000000", {req0_if.ready, req1_if.ready, shd_in_if.valid, shd_out_if.ready, resp0_if.valid, resp1_if.valid});
        end
        checks++;
        if ({shd_in_if.data, resp0_if.data, resp1_if.data} !== 51'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0", shd_in_if.data, resp0_if.data, resp1_if.data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        req0_if.valid = 1'b1; req0_if.data = 17'h1;
        req1_if.valid = 1'b1; req1_if.data = 17'h2;
        shd_in_if.ready = 1'b1;
        #1;
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.valid} !== 3'b000) begin
            errors++; $display("FAIL cont_bubble0 got %b exp 000", {req0_if.ready, req1_if.ready, shd_in_if.valid});
        end
        tick();
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.valid, shd_in_if.data} !== {3'b101, 17'h1}) begin
            errors++; $display("FAIL cont_lock0 got rdy %b%b v %b d %h exp 10 1 00001", req0_if.ready, req1_if.ready, shd_in_if.valid, shd_in_if.data);
        end
        tick();
        req0_if.data = c_DONE;
        tick();
        req0_if.valid = 1'b0;
        #1;
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.valid} !== 3'b000) begin
            errors++; $display("FAIL cont_bubble1 got %b exp 000", {req0_if.ready, req1_if.ready, shd_in_if.valid});
        end
        tick();
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.valid, shd_in_if.data} !== {3'b011, 17'h2}) begin
            errors++; $display("FAIL cont_lock1 got rdy %b%b v %b d %h exp 01 1 00002", req0_if.ready, req1_if.ready, shd_in_if.valid, shd_in_if.data);
        end
        tick();
        req1_if.data = c_DONE;
        tick();
        req1_if.valid = 1'b0;
        resp0_if.ready = 1'b1; resp1_if.ready = 1'b1;
        shd_out_if.valid = 1'b1; shd_out_if.data = 17'h9;
        #1;
        checks++;
        if ({resp0_if.valid, resp1_if.valid, resp0_if.data} !== {2'b10, 17'h9}) begin
            errors++; $display("FAIL cont_route0 got v %b%b d %h exp 10 00009", resp0_if.valid, resp1_if.valid, resp0_if.data);
        end
        tick();
        shd_out_if.data = c_DONE;
        tick();
        shd_out_if.data = 17'h8;
        #1;
        checks++;
        if ({resp0_if.valid, resp1_if.valid, resp1_if.data} !== {2'b01, 17'h8}) begin
            errors++; $display("FAIL cont_route1 got v %b%b d %h exp 01 00008", resp0_if.valid, resp1_if.valid, resp1_if.data);
        end
        tick();
        shd_out_if.data = c_DONE;
        tick();
        shd_out_if.valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL cont_drained got busy %b exp 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_single_stream();
        logic [16:0] toks [4];
        toks[0] = 17'h5; toks[1] = 17'h7; toks[2] = 17'h10000; toks[3] = c_DONE;
        req0_if.valid = 1'b1; req0_if.data = toks[0];
        shd_in_if.ready = 1'b1; resp0_if.ready = 1'b1; resp1_if.ready = 1'b1;
        #1;
        checks++;
        if (req0_if.ready !== 1'b0) begin
            errors++; $display("FAIL single_bubble got %b exp 0", req0_if.ready);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            req0_if.data = toks[i];
            #1;
            checks++;
            if ({req0_if.ready, shd_in_if.valid, shd_in_if.data} !== {2'b11, toks[i]}) begin
                errors++; $display("FAIL single_in%0d got r %b v %b d %h exp 1 1 %h", i, req0_if.ready, shd_in_if.valid, shd_in_if.data, toks[i]);
            end
            tick();
        end
        req0_if.valid = 1'b0;
        #1;
        checks++;
        if ({shd_in_if.valid, busy} !== 2'b01) begin
            errors++; $display("FAIL single_released got v %b busy %b exp 0 1", shd_in_if.valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            shd_out_if.valid = 1'b1; shd_out_if.data = toks[i];
            #1;
            checks++;
            if ({resp0_if.valid, resp1_if.valid, shd_out_if.ready, resp0_if.data} !== {3'b101, toks[i]}) begin
                errors++; $display("FAIL single_out%0d got v %b%b r %b d %h exp 10 1 %h", i, resp0_if.valid, resp1_if.valid, shd_out_if.ready, resp0_if.data, toks[i]);
            end
            tick();
        end
        shd_out_if.valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_drained got busy %b exp 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_stop_passthrough();
        logic [16:0] toks [4];
        toks[0] = 17'h3; toks[1] = 17'h10001; toks[2] = 17'h4; toks[3] = c_DONE;
        req0_if.valid = 1'b1; req0_if.data = 17'h55;
        req1_if.valid = 1'b1; req1_if.data = toks[0];
        shd_in_if.ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            req1_if.data = toks[i];
            #1;
            checks++;
            if ({req0_if.ready, req1_if.ready, shd_in_if.data} !== {2'b01, toks[i]}) begin
                errors++; $display("FAIL stop_lock%0d got rdy %b%b d %h exp 01 %h", i, req0_if.ready, req1_if.ready, shd_in_if.data, toks[i]);
            end
            tick();
        end
        req0_if.valid = 1'b0; req1_if.valid = 1'b0;
        shd_out_if.valid = 1'b1; shd_out_if.data = c_DONE;
        resp0_if.ready = 1'b1; resp1_if.ready = 1'b1;
        #1;
        checks++;
        if ({resp0_if.valid, resp1_if.valid} !== 2'b01) begin
            errors++; $display("FAIL stop_route got %b exp 01", {resp0_if.valid, resp1_if.valid});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [16:0] toks [4];
        logic [16:0] got [$];
        logic        xfer;
        logic [16:0] seen;
        int          k;
        int          cyc;
        toks[0] = 17'h11; toks[1] = 17'h22; toks[2] = 17'h33; toks[3] = c_DONE;
        req0_if.valid = 1'b1; req0_if.data = toks[0];
        tick();
        k = 0; cyc = 0;
        while (k < 4 && cyc < 20) begin
            shd_in_if.ready = ((cyc % 2) == 0);
            req0_if.data = toks[k];
            #1;
            checks++;
            if ({req0_if.ready, shd_in_if.valid} !== {shd_in_if.ready, 1'b1}) begin
                errors++; $display("FAIL bp_in_cyc%0d got r %b v %b exp %b 1", cyc, req0_if.ready, shd_in_if.valid, shd_in_if.ready);
            end
            xfer = shd_in_if.valid && shd_in_if.ready;
            seen = shd_in_if.data;
            tick();
            if (xfer) begin
                got.push_back(seen);
                k++;
            end
            cyc++;
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_count got %0d exp 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== toks[i]) begin
                    errors++; $display("FAIL bp_tok%0d got %h exp %h", i, got[i], toks[i]);
                end
            end
        end
        req0_if.valid = 1'b0; shd_in_if.ready = 1'b0;
        shd_out_if.valid = 1'b1; shd_out_if.data = 17'h44;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({shd_out_if.ready, resp0_if.valid, resp1_if.valid} !== 3'b010) begin
                errors++; $display("FAIL bp_out_stall%0d got %b exp 010", i, {shd_out_if.ready, resp0_if.valid, resp1_if.valid});
            end
            tick();
        end
        resp0_if.ready = 1'b1;
        #1;
        checks++;
        if ({shd_out_if.ready, resp0_if.data} !== {1'b1, 17'h44}) begin
            errors++; $display("FAIL bp_out_resume got r %b d %h exp 1 00044", shd_out_if.ready, resp0_if.data);
        end
        tick();
        shd_out_if.data = c_DONE;
        tick();
        shd_out_if.valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_drained got busy %b exp 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        req0_if.valid = 1'b1; req0_if.data = c_DONE;
        req1_if.valid = 1'b1; req1_if.data = c_DONE;
        shd_in_if.ready = 1'b1;
        tick();
        checks++;
        if ({req0_if.ready, req1_if.ready} !== 2'b01) begin
            errors++; $display("FAIL full_grant1 got %b exp 01", {req0_if.ready, req1_if.ready});
        end
        tick(); tick();
        checks++;
        if ({req0_if.ready, req1_if.ready} !== 2'b10) begin
            errors++; $display("FAIL full_grant0 got %b exp 10", {req0_if.ready, req1_if.ready});
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_if.ready, req1_if.ready, shd_in_if.valid, busy} !== 4'b0001) begin
                errors++; $display("FAIL full_hold%0d got %b exp 0001", i, {req0_if.ready, req1_if.ready, shd_in_if.valid, busy});
            end
            tick();
        end
        shd_out_if.valid = 1'b1; shd_out_if.data = c_DONE; resp1_if.ready = 1'b1;
        #1;
        checks++;
        if ({resp0_if.valid, resp1_if.valid, shd_out_if.ready} !== 3'b011) begin
            errors++; $display("FAIL full_pop got %b exp 011", {resp0_if.valid, resp1_if.valid, shd_out_if.ready});
        end
        tick();
        shd_out_if.valid = 1'b0; resp1_if.ready = 1'b0;
        #1;
        checks++;
        if ({req0_if.ready, req1_if.ready} !== 2'b00) begin
            errors++; $display("FAIL full_bubble got %b exp 00", {req0_if.ready, req1_if.ready});
        end
        tick();
        checks++;
        if ({req0_if.ready, req1_if.ready} !== 2'b01) begin
            errors++; $display("FAIL full_third_grant got %b exp 01", {req0_if.ready, req1_if.ready});
        end
        tick();
        req0_if.valid = 1'b0; req1_if.valid = 1'b0;
        resp0_if.ready = 1'b1; resp1_if.ready = 1'b1;
        shd_out_if.valid = 1'b1; shd_out_if.data = c_DONE;
        #1;
        checks++;
        if ({resp0_if.valid, resp1_if.valid} !== 2'b10) begin
            errors++; $display("FAIL full_drain0 got %b exp 10", {resp0_if.valid, resp1_if.valid});
        end
        tick();
        checks++;
        if ({resp0_if.valid, resp1_if.valid} !== 2'b01) begin
            errors++; $display("FAIL full_drain1 got %b exp 01", {resp0_if.valid, resp1_if.valid});
        end
        tick();
        shd_out_if.valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL full_drained got busy %b exp 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        req0_if.valid = 1'b1; req0_if.data = 17'hA;
        shd_in_if.ready = 1'b1; resp0_if.ready = 1'b1; resp1_if.ready = 1'b1;
        tick(); tick();
        req0_if.data = 17'hB;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        shd_out_if.valid = 1'b1; shd_out_if.data = c_DONE;
        #1;
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.valid, shd_out_if.ready, resp0_if.valid, resp1_if.valid, busy} !== 7'b0) begin
            errors++; $display("FAIL flush_clear got %b exp 0000000", {req0_if.ready, req1_if.ready, shd_in_if.valid, shd_out_if.ready, resp0_if.valid, resp1_if.valid, busy});
        end
        req0_if.valid = 1'b0; shd_out_if.valid = 1'b0;
        req1_if.valid = 1'b1; req1_if.data = 17'h5;
        tick();
        checks++;
        if ({req0_if.ready, req1_if.ready, shd_in_if.data} !== {2'b01, 17'h5}) begin
            errors++; $display("FAIL flush_regrant got rdy %b%b d %h exp 01 00005", req0_if.ready, req1_if.ready, shd_in_if.data);
        end
        tick();
        req1_if.data = c_DONE;
        tick();
        req1_if.valid = 1'b0;
        shd_out_if.valid = 1'b1; shd_out_if.data = c_DONE;
        #1;
        checks++;
        if ({resp0_if.valid, resp1_if.valid} !== 2'b01) begin
            errors++; $display("FAIL flush_route got %b exp 01", {resp0_if.valid, resp1_if.valid});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_enables();
        req0_if.valid = 1'b1; req0_if.data = 17'h3;
        tick();
        clk_en = 1'b0;
        #1;
        checks++;
        if ({shd_in_if.valid, req0_if.ready} !== 2'b00) begin
            errors++; $display("FAIL en_frozen got %b exp 00", {shd_in_if.valid, req0_if.ready});
        end
        tick();
        clk_en = 1'b1;
        #1;
        checks++;
        if ({shd_in_if.valid, shd_in_if.data, busy} !== {1'b1, 17'h3, 1'b1}) begin
            errors++; $display("FAIL en_held got v %b d %h busy %b exp 1 00003 1", shd_in_if.valid, shd_in_if.data, busy);
        end
        tile_en = 1'b0;
        tick();
        tile_en = 1'b1;
        shd_in_if.ready = 1'b1;
        #1;
        checks++;
        if ({req0_if.ready, shd_in_if.valid, busy} !== 3'b000) begin
            errors++; $display("FAIL en_tile_clear got %b exp 000", {req0_if.ready, shd_in_if.valid, busy});
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_stream();
        test_stop_passthrough();
        test_backpressure();
        test_fifo_full();
        test_flush();
        test_enables();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/repsig_stream_arbiter.md
Name: repsig_stream_arbiter

Overview:
- Shares one RepeatSignalGenerator between two upstream requesters on 17-bit ready/valid sparse token streams.
- Grants the shared input one whole stream at a time. A stream runs from its first token through its done token.
- Records grant order in a small order FIFO. Steers the generator's output stream back to the owning requester, also at done-token granularity.
- Sits between two scanner/glb streams and the shared repeat unit, inside the sparse tile.

Parameters:
DATA_WIDTH, 17, token width; bit DATA_WIDTH-1 = control flag
DONE_TOKEN, 17'h10100, control token that terminates a stream
ORDER_DEPTH, 4, order FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clk_en  in  1  global clock enable; low = state frozen, all output valid/ready driven 0
flush  in  1  synchronous clear, same effect as rst
tile_en  in  1  low = block idle: state held at reset values, all output valid/ready 0
req0_data  in  17  requester 0 token
req0_valid  in  1  requester 0 valid
req0_ready  out  1  requester 0 ready
req1_data  in  17  requester 1 token
req1_valid  in  1
req1_ready  out  1
shd_in_data  out  17  to shared generator base_data_in
shd_in_valid  out  1
shd_in_ready  in  1
shd_out_data  in  17  from shared generator repsig_data_out
shd_out_valid  in  1
shd_out_ready  out  1
resp0_data  out  17  response stream to requester 0
resp0_valid  out  1
resp0_ready  in  1
resp1_data  out  17  response stream to requester 1
resp1_valid  in/out: out  1
resp1_ready  in  1
busy  out  1  high when the input FSM is not IDLE or the order FIFO is non-empty

Behaviour:
- Handshake: transfer = valid & ready on the same rising clk edge. Valid never depends combinationally on the same-side ready.
- Reset (rst or flush, checked at the edge):
  - input FSM -> IDLE; round-robin pointer rr = 0; order FIFO emptied.
  - all valid/ready outputs 0; data outputs 0; busy 0.
- Input FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: all req*_ready = 0 and shd_in_valid = 0. If the order FIFO is not full and any req*_valid is high, grant to requester rr if it is valid, else to the other.
    - Next state is LOCKn. Push n into the order FIFO on that same edge.
    - This costs one bubble cycle per stream.
  - IDLE with both valid and rr=1 grants req1. With FIFO full, stay in IDLE.
  - LOCKn: shd_in_data = reqn_data, shd_in_valid = reqn_valid, reqn_ready = shd_in_ready. The other requester's ready = 0.
    - On a transfer of a token equal to DONE_TOKEN: go to IDLE and set rr = 1-n.
    - Any other token, including stop tokens (bit16=1, [15:8]=0), passes through unchanged without ending the lock.
- Output side is combinational from the order FIFO head h:
  - FIFO empty: shd_out_ready = 0, resp*_valid = 0. Generator output stalls and nothing is dropped.
  - FIFO non-empty: resph_valid = shd_out_valid, resph_data = shd_out_data, shd_out_ready = resph_ready. The other resp valid = 0.
  - On a transfer of DONE_TOKEN on shd_out: pop the head.
- Order FIFO: ORDER_DEPTH x 1 bit, with rd/wr pointers plus count.
  - Push and pop in the same cycle are legal when non-empty; count is unchanged.
  - Push while full is impossible by construction; assert it never happens.
- Latency: zero-cycle combinational pass-through while locked, plus a one-cycle grant bubble per stream. No data buffering in the block.
- clk_en=0 or tile_en=0: no transfers occur; FSM, rr and FIFO hold. With tile_en=0, reset values are forced as well.
- Reset mid-stream aborts both sides immediately. Requesters must be flushed together with this block.

Decomposition:
- Shared package sparse_tok_pkg holds:
  - the TOKEN_W=17 constant;
  - DONE_TOKEN, STOP_TOKEN_BASE=17'h10000;
  - is_done() and is_stop() functions;
  - arb_state_t enum {IDLE, LOCK0, LOCK1}.
- One sub-module, arb_order_fifo (1-bit-wide synchronous FIFO with full/empty), keeps the FIFO logic out of the FSM.

Test Plan:
- Single stream: req0 sends 5, 7, 10000, 10100 with shd_in_ready=1. Expect shd_in tokens on cycles 2-5 after valid; the generator output stream appears on resp0 only; resp1_valid stays 0.
- Contention: req0 and req1 both valid from cycle 0. Expect the req0 stream (rr=0) to complete, ending with DONE, then one bubble, then the req1 stream. Order FIFO holds 0,1 and responses route 0 then 1.
- Stop token passthrough: req1 sends 3, 10001, 4, 10100. Expect 10001 not to release the lock; req0_ready = 0 until after 10100 transfers.
- Backpressure: shd_in_ready toggles 1010 and resp0_ready is held 0 for 6 cycles. Expect no token loss or duplication, and shd_out_ready = 0 while resp0_ready = 0.
- FIFO full: set ORDER_DEPTH=2, hold shd_out_ready off by keeping resp*_ready=0, and send 3 streams. Expect the 3rd grant delayed until the first response DONE pops; the FIFO-full assertion never fires.
- Flush mid-stream: after 2 tokens of the req0 stream, pulse flush for 1 cycle. Expect IDLE, empty FIFO, all valid/ready outputs 0 next cycle, busy=0, and a fresh req1 stream granted normally afterwards.
